regfile_mp_bypass: RTL and testbench

- Parametrised successor of the team's 32x128-bit wide-word register file.
- Generalises data width and depth, registers both read ports, and adds write-to-read bypass.
- Adds a per-register busy scoreboard so the processor pipeline can detect pending results.
- Sits between decode (read and reserve) and writeback (write) in the wide-word processor.

---
 rtl/regfile_mp_bypass.sv | 94 +++++++++
 tb/tb_regfile_mp_bypass.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/regfile_mp_bypass.sv
// regfile_mp_bypass: wide-word register file with two registered read ports, byte-enabled write,
// optional write-to-read bypass and a per-register busy scoreboard.
module regfile_mp_bypass #(
    parameter int WIDTH     = 128,
    parameter int ADDR_W    = 5,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG0 = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     wrdata,
    input  logic [ADDR_W-1:0]    wraddr,
    input  logic                 wren,
    input  logic [WIDTH/8-1:0]   wrbyteen,
    input  logic [ADDR_W-1:0]    rd1addr,
    input  logic                 rd1en,
    input  logic [ADDR_W-1:0]    rd2addr,
    input  logic                 rd2en,
    input  logic                 rsven,
    input  logic [ADDR_W-1:0]    rsvaddr,
    output logic [WIDTH-1:0]     rd1data,
    output logic [WIDTH-1:0]     rd2data,
    output logic                 rd1busy,
    output logic                 rd2busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [DEPTH-1:0]          busy, busy_nxt;
    logic [WIDTH-1:0]          bmask, merged;
    logic                      wr_ok, rsv_ok, rsv_same;
    logic [1:0][ADDR_W-1:0]    raddr;
    logic [1:0][WIDTH-1:0]     rval;
    logic [1:0]                rbsy, hit, zr;

    // Register 0 swallows writes and reserves when hardwired to zero
    assign wr_ok    = wren && !(ZERO_REG0 != 0 && wraddr == '0);
    assign rsv_ok   = rsven && !(ZERO_REG0 != 0 && rsvaddr == '0);
    assign rsv_same = rsv_ok && rsvaddr == wraddr;
    assign merged   = (mem[wraddr] & ~bmask) | (wrdata & bmask);
    assign raddr    = {rd2addr, rd1addr};

    always_comb begin
        bmask = '0;
        for (int i = 0; i < WIDTH / 8; i++)
            bmask[8*i +: 8] = {8{wrbyteen[i]}};
    end

    // Reserve is applied after the write so it wins on a shared address
    always_comb begin
        busy_nxt = busy;
        if (wr_ok)
            busy_nxt[wraddr] = 1'b0;
        if (rsv_ok)
            busy_nxt[rsvaddr] = 1'b1;
    end

    always_comb begin
        hit  = '0;
        zr   = '0;
        rval = '0;
        rbsy = '0;
        for (int p = 0; p < 2; p++) begin
            zr[p]   = ZERO_REG0 != 0 && raddr[p] == '0;
            hit[p]  = BYPASS != 0 && wr_ok && raddr[p] == wraddr;
            rval[p] = zr[p] ? '0 : hit[p] ? merged : mem[raddr[p]];
            rbsy[p] = zr[p] ? 1'b0 : hit[p] ? rsv_same : busy[raddr[p]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            busy    <= '0;
            rd1data <= '0;
            rd2data <= '0;
            rd1busy <= 1'b0;
            rd2busy <= 1'b0;
        end else begin
            if (wr_ok)
                mem[wraddr] <= merged;
            busy <= busy_nxt;
            if (rd1en) begin
                rd1data <= rval[0];
                rd1busy <= rbsy[0];
            end
            if (rd2en) begin
                rd2data <= rval[1];
                rd2busy <= rbsy[1];
            end
        end
    end
endmodule

// File: tb/tb_regfile_mp_bypass.sv
// tb_regfile_mp_bypass: directed checks of the register file with bypass on, bypass off and register 0 hardwired.
module tb_regfile_mp_bypass;
    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] wrdata;
    logic [4:0]   wraddr, rd1addr, rd2addr, rsvaddr;
    logic         wren, rd1en, rd2en, rsven;
    logic [15:0]  wrbyteen;
    logic [127:0] d_rd1data, d_rd2data, n_rd1data, n_rd2data, z_rd1data, z_rd2data;
    logic         d_rd1busy, d_rd2busy, n_rd1busy, n_rd2busy, z_rd1busy, z_rd2busy;
    int           vectors = 0;
    int           errs = 0;

    localparam logic [127:0] D0   = 128'h787897ea12fec60cae787897eac22354;
    localparam logic [127:0] R0   = 128'h0000000000000000ae787897eac22354;
    localparam logic [127:0] D7   = 128'hc65da4654cad646c5d4a564cd56ca552;
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] MRG  = {96'hffffffffffffffffffffffff, 32'h12345678};
    localparam logic [127:0] D5   = 128'h5555aaaa5555aaaa0123456789abcdef;

    always #5 clk = ~clk;

    regfile_mp_bypass dut (.clk(clk), .reset(reset), .wrdata(wrdata), .wraddr(wraddr), .wren(wren),
        .wrbyteen(wrbyteen), .rd1addr(rd1addr), .rd1en(rd1en), .rd2addr(rd2addr), .rd2en(rd2en),
        .rsven(rsven), .rsvaddr(rsvaddr), .rd1data(d_rd1data), .rd2data(d_rd2data),
        .rd1busy(d_rd1busy), .rd2busy(d_rd2busy));

    regfile_mp_bypass #(.BYPASS(0)) dut_nb (.clk(clk), .reset(reset), .wrdata(wrdata), .wraddr(wraddr),
        .wren(wren), .wrbyteen(wrbyteen), .rd1addr(rd1addr), .rd1en(rd1en), .rd2addr(rd2addr),
        .rd2en(rd2en), .rsven(rsven), .rsvaddr(rsvaddr), .rd1data(n_rd1data), .rd2data(n_rd2data),
        .rd1busy(n_rd1busy), .rd2busy(n_rd2busy));

    regfile_mp_bypass #(.ZERO_REG0(1)) dut_z (.clk(clk), .reset(reset), .wrdata(wrdata), .wraddr(wraddr),
        .wren(wren), .wrbyteen(wrbyteen), .rd1addr(rd1addr), .rd1en(rd1en), .rd2addr(rd2addr),
        .rd2en(rd2en), .rsven(rsven), .rsvaddr(rsvaddr), .rd1data(z_rd1data), .rd2data(z_rd2data),
        .rd1busy(z_rd1busy), .rd2busy(z_rd2busy));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; wrdata = '0; wraddr = '0; wren = 1'b0; wrbyteen = '0;
        rd1addr = '0; rd1en = 1'b0; rd2addr = '0; rd2en = 1'b0; rsven = 1'b0; rsvaddr = '0;
        #12 reset = 1'b0;
        tick;
        chk("reset_rd1data", d_rd1data, '0);
        chk("reset_rd2data", d_rd2data, '0);
        chk("reset_busy", {d_rd1busy, d_rd2busy}, '0);

        wren = 1'b1; wraddr = 5'd0; wrbyteen = 16'h00ff; wrdata = D0;
        tick;
        wren = 1'b0; rd1en = 1'b1; rd1addr = 5'd0;
        tick;
        chk("byte_write_addr0", d_rd1data, R0);
        chk("zero_reg0_read", z_rd1data, '0);

        wren = 1'b1; wraddr = 5'd7; wrbyteen = 16'hffff; wrdata = D7; rd1en = 1'b0;
        tick;
        wren = 1'b0; rd1en = 1'b1; rd1addr = 5'd7; rd2en = 1'b1; rd2addr = 5'd0;
        tick;
        chk("dual_rd1_addr7", d_rd1data, D7);
        chk("dual_rd2_addr0", d_rd2data, R0);
        chk("zero_reg0_rd2", z_rd2data, '0);
        rd2addr = 5'd7;
        tick;
        chk("same_addr_rd1", d_rd1data, D7);
        chk("same_addr_rd2", d_rd2data, D7);

        wren = 1'b1; wraddr = 5'd3; wrbyteen = 16'hffff; wrdata = ONES; rd1en = 1'b0; rd2en = 1'b0;
        tick;
        wrbyteen = 16'h000f; wrdata = 128'h12345678; rd1en = 1'b1; rd1addr = 5'd3;
        tick;
        chk("bypass_on_data", d_rd1data, MRG);
        chk("bypass_on_busy", d_rd1busy, '0);
        chk("bypass_off_data", n_rd1data, ONES);
        wren = 1'b0;
        tick;
        chk("after_bypass_on", d_rd1data, MRG);
        chk("after_bypass_off", n_rd1data, MRG);

        rd1en = 1'b0; wren = 1'b1; wraddr = 5'd3; wrbyteen = 16'hffff; wrdata = '0;
        tick;
        chk("hold_rd1", d_rd1data, MRG);
        chk("hold_rd2", d_rd2data, D7);

        wren = 1'b0; rsven = 1'b1; rsvaddr = 5'd5;
        tick;
        rsven = 1'b0; rd1en = 1'b1; rd1addr = 5'd5;
        tick;
        chk("reserved_busy", d_rd1busy, 1'b1);
        rd1en = 1'b0; wren = 1'b1; wraddr = 5'd5; wrbyteen = 16'h0000; wrdata = ONES;
        tick;
        wren = 1'b0; rd1en = 1'b1;
        tick;
        chk("write_clears_busy", d_rd1busy, 1'b0);
        chk("empty_byteen_data", d_rd1data, '0);
        wren = 1'b1; wrbyteen = 16'hffff; wrdata = D5; rsven = 1'b1; rsvaddr = 5'd5;
        tick;
        chk("rsv_wins_bypass_busy", d_rd1busy, 1'b1);
        chk("rsv_wins_bypass_data", d_rd1data, D5);
        chk("nobypass_old_busy", n_rd1busy, 1'b0);
        chk("nobypass_old_data", n_rd1data, '0);
        wren = 1'b0; rsven = 1'b0;
        tick;
        chk("rsv_wins_busy_on", d_rd1busy, 1'b1);
        chk("rsv_wins_busy_off", n_rd1busy, 1'b1);
        chk("rsv_write_landed", n_rd1data, D5);

        rd1en = 1'b0; rsven = 1'b1; rsvaddr = 5'd0;
        tick;
        rsven = 1'b0; rd2en = 1'b1; rd2addr = 5'd0;
        tick;
        chk("reg0_busy_normal", d_rd2busy, 1'b1);
        chk("reg0_never_busy", z_rd2busy, 1'b0);

        rd2en = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("async_rd1data", d_rd1data, '0);
        chk("async_rd2data", d_rd2data, '0);
        chk("async_busy", {d_rd1busy, d_rd2busy, n_rd1busy}, '0);
        chk("async_nb_data", n_rd1data | n_rd2data, '0);
        #2 reset = 1'b0;
        rd1en = 1'b1; rd2en = 1'b1;
        for (int a = 0; a < 32; a++) begin
            rd1addr = 5'(a); rd2addr = 5'(31 - a);
            tick;
            chk($sformatf("post_reset_data_%0d", a), d_rd1data | d_rd2data | n_rd1data | n_rd2data, '0);
            chk($sformatf("post_reset_busy_%0d", a), {d_rd1busy, d_rd2busy, n_rd1busy, n_rd2busy}, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
